// File: rtl/ob_cntrl_mk_apply.sv
// ob_cntrl_mk_apply: queries the trade decision block, applies the decision to the book queues and emits the executed trade.
package ob_pkg;
  typedef logic [15:0] quantity_t;
  typedef struct packed {
    logic mk_ask_lm_bid;
    logic lm_ask_mk_bid;
    logic mk_ask_mk_bid;
    logic ask_consumed;
    logic bid_consumed;
    quantity_t quantity;
    quantity_t remainder;
  } search_result_t;
endpackage

module ob_cntrl_mk_apply
  import ob_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  output logic           trade_qry,
  input  logic           trade_vld_r,
  input  search_result_t trade_r,
  output logic           mk_bid_pop,
  output logic           mk_ask_pop,
  output logic           lm_bid_pop,
  output logic           lm_ask_pop,
  output logic           mk_bid_upd,
  output logic           mk_ask_upd,
  output logic           lm_bid_upd,
  output logic           lm_ask_upd,
  output quantity_t      upd_quantity,
  output logic           rsp_vld,
  input  logic           rsp_rdy,
  output search_result_t rsp_r,
  output logic           busy,
  output logic [15:0]    trade_cnt_r,
  output logic           err_r
);
  typedef enum logic [2:0] {IDLE, QRY, WAIT, APPLY, EMIT, SETTLE} state_t;
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  state_t         state;
  logic [3:0]     cnt;
  search_result_t hold;
  logic           in_bad, hold_bad, ask_mk, ask_lm, bid_mk, bid_lm;
  function automatic logic malformed(input search_result_t r);
    logic [2:0] t;
    t = {r.mk_ask_lm_bid, r.lm_ask_mk_bid, r.mk_ask_mk_bid};
    return (t == 3'b0) || ((t & (t - 3'd1)) != 3'b0) || !(r.ask_consumed || r.bid_consumed);
  endfunction
  always_comb begin
    in_bad   = malformed(trade_r);
    hold_bad = malformed(hold);
    ask_mk   = trade_r.mk_ask_lm_bid | trade_r.mk_ask_mk_bid;
    ask_lm   = trade_r.lm_ask_mk_bid;
    bid_lm   = trade_r.mk_ask_lm_bid;
    bid_mk   = trade_r.lm_ask_mk_bid | trade_r.mk_ask_mk_bid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      hold         <= '0;
      trade_qry    <= 1'b0;
      mk_bid_pop   <= 1'b0;
      mk_ask_pop   <= 1'b0;
      lm_bid_pop   <= 1'b0;
      lm_ask_pop   <= 1'b0;
      mk_bid_upd   <= 1'b0;
      mk_ask_upd   <= 1'b0;
      lm_bid_upd   <= 1'b0;
      lm_ask_upd   <= 1'b0;
      upd_quantity <= '0;
      rsp_vld      <= 1'b0;
      rsp_r        <= '0;
      busy         <= 1'b0;
      trade_cnt_r  <= '0;
      err_r        <= 1'b0;
    end else begin
      trade_qry    <= 1'b0;
      mk_bid_pop   <= 1'b0;
      mk_ask_pop   <= 1'b0;
      lm_bid_pop   <= 1'b0;
      lm_ask_pop   <= 1'b0;
      mk_bid_upd   <= 1'b0;
      mk_ask_upd   <= 1'b0;
      lm_bid_upd   <= 1'b0;
      lm_ask_upd   <= 1'b0;
      upd_quantity <= '0;
      case (state)
        IDLE: if (en) begin
          state     <= QRY;
          trade_qry <= 1'b1;
          busy      <= 1'b1;
        end
        QRY: state <= WAIT;
        WAIT: if (trade_vld_r) begin
          // strobes are decided here so they are registered exactly for the APPLY cycle
          hold  <= trade_r;
          state <= APPLY;
          if (!in_bad) begin
            mk_ask_pop   <= ask_mk & trade_r.ask_consumed;
            lm_ask_pop   <= ask_lm & trade_r.ask_consumed;
            mk_ask_upd   <= ask_mk & !trade_r.ask_consumed;
            lm_ask_upd   <= ask_lm & !trade_r.ask_consumed;
            mk_bid_pop   <= bid_mk & trade_r.bid_consumed;
            lm_bid_pop   <= bid_lm & trade_r.bid_consumed;
            mk_bid_upd   <= bid_mk & !trade_r.bid_consumed;
            lm_bid_upd   <= bid_lm & !trade_r.bid_consumed;
            upd_quantity <= (trade_r.ask_consumed & trade_r.bid_consumed) ? '0 : trade_r.remainder;
          end
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        APPLY: if (hold_bad) begin
          err_r <= 1'b1;
          cnt   <= SETTLE_INIT;
          state <= SETTLE;
        end else begin
          rsp_vld <= 1'b1;
          rsp_r   <= hold;
          state   <= EMIT;
        end
        EMIT: if (rsp_rdy) begin
          rsp_vld     <= 1'b0;
          trade_cnt_r <= trade_cnt_r + 16'd1;
          cnt         <= SETTLE_INIT;
          state       <= SETTLE;
        end
        SETTLE: if (cnt == 4'd0) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ob_cntrl_mk_apply.sv
// tb_ob_cntrl_mk_apply: directed plus randomized trades checked against a side/strobe reference model.
module tb_ob_cntrl_mk_apply;
  import ob_pkg::*;
  localparam int S = 2;
  logic clk = 0, rst_n = 0, en = 0, trade_vld_r = 0, rsp_rdy = 0;
  search_result_t trade_r = '0;
  logic trade_qry, mk_bid_pop, mk_ask_pop, lm_bid_pop, lm_ask_pop;
  logic mk_bid_upd, mk_ask_upd, lm_bid_upd, lm_ask_upd, rsp_vld, busy, err_r;
  quantity_t upd_quantity;
  search_result_t rsp_r;
  logic [15:0] trade_cnt_r;
  logic [7:0] strobes;
  logic [43:0] ctl;
  int vecs = 0, errs = 0;
  logic [15:0] exp_cnt = 0;
  logic exp_err = 0;

  ob_cntrl_mk_apply #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .trade_qry(trade_qry),
    .trade_vld_r(trade_vld_r), .trade_r(trade_r),
    .mk_bid_pop(mk_bid_pop), .mk_ask_pop(mk_ask_pop), .lm_bid_pop(lm_bid_pop), .lm_ask_pop(lm_ask_pop),
    .mk_bid_upd(mk_bid_upd), .mk_ask_upd(mk_ask_upd), .lm_bid_upd(lm_bid_upd), .lm_ask_upd(lm_ask_upd),
    .upd_quantity(upd_quantity), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_r(rsp_r),
    .busy(busy), .trade_cnt_r(trade_cnt_r), .err_r(err_r)
  );

  assign strobes = {mk_ask_pop, mk_bid_pop, lm_ask_pop, lm_bid_pop, mk_ask_upd, mk_bid_upd, lm_ask_upd, lm_bid_upd};
  assign ctl = {trade_qry, strobes, upd_quantity, rsp_vld, busy, trade_cnt_r, err_r};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_qry(output int n);
    n = 0;
    while (trade_qry !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("qry_timeout", trade_qry, 1);
  endtask

  function automatic search_result_t mk_rec(input logic [2:0] t, input logic a, input logic b,
                                            input int q, input int rem);
    search_result_t r;
    r = '0;
    {r.mk_ask_lm_bid, r.lm_ask_mk_bid, r.mk_ask_mk_bid} = t;
    r.ask_consumed = a;
    r.bid_consumed = b;
    r.quantity = 16'(q);
    r.remainder = 16'(rem);
    return r;
  endfunction

  function automatic search_result_t rand_rec();
    int p;
    logic [2:0] t;
    p = $urandom_range(0, 9);
    t = (p < 8) ? 3'(1 << (p % 3)) : 3'($urandom);
    return mk_rec(t, 1'($urandom), 1'($urandom), $urandom_range(1, 65535), $urandom_range(1, 65535));
  endfunction

  // One full transaction: answer the query with rec, then follow it through APPLY/EMIT/SETTLE.
  task automatic run(input search_result_t rec, input logic vld, input int rdy_wait, input logic chk_lat);
    int n;
    logic good;
    logic [7:0] exp_s;
    logic ask_mk, bid_mk;
    wait_qry(n);
    check("qry_busy", busy, 1);
    @(negedge clk);
    check("qry_one_cycle", trade_qry, 0);
    trade_vld_r = vld;
    trade_r = rec;
    @(negedge clk);
    trade_vld_r = 0;
    trade_r = search_result_t'(37'({$urandom, $urandom}));
    good = vld && $countones({rec.mk_ask_lm_bid, rec.lm_ask_mk_bid, rec.mk_ask_mk_bid}) == 1
           && (rec.ask_consumed || rec.bid_consumed);
    ask_mk = !rec.lm_ask_mk_bid;
    bid_mk = !rec.mk_ask_lm_bid;
    exp_s = '0;
    if (good) begin
      exp_s[(ask_mk ? 7 : 5) - (rec.ask_consumed ? 0 : 4)] = 1'b1;
      exp_s[(bid_mk ? 6 : 4) - (rec.bid_consumed ? 0 : 4)] = 1'b1;
    end
    check("apply_strobes", strobes, exp_s);
    check("apply_upd_qty", upd_quantity, (good && !(rec.ask_consumed && rec.bid_consumed)) ? rec.remainder : 16'd0);
    check("apply_no_rsp", rsp_vld, 0);
    if (!vld) begin
      check("novld_idle", busy, 0);
      @(negedge clk);
      check("novld_requery", trade_qry, 1);
    end else if (!good) begin
      exp_err = 1;
      @(negedge clk);
      check("bad_err", err_r, 1);
      check("bad_no_rsp", rsp_vld, 0);
      check("bad_no_strobe", strobes, 0);
    end else begin
      @(negedge clk);
      check("emit_strobes_off", strobes, 0);
      check("emit_upd_qty", upd_quantity, 0);
      for (int i = 0; i <= rdy_wait; i++) begin
        rsp_rdy = (i == rdy_wait);
        check("emit_vld", rsp_vld, 1);
        check("emit_rsp", rsp_r, rec);
        check("emit_cnt_hold", trade_cnt_r, exp_cnt);
        @(negedge clk);
      end
      rsp_rdy = 0;
      exp_cnt++;
      check("post_rsp_vld", rsp_vld, 0);
      if (chk_lat) begin
        wait_qry(n);
        check("loop_latency", n, S + 1);
      end
    end
    check("trade_cnt", trade_cnt_r, exp_cnt);
    check("err_sticky", err_r, exp_err);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    check("reset_ctl", ctl, 0);
    check("reset_rsp", rsp_r, 0);
    rst_n = 1;
    en = 1;
    run(mk_rec(3'b001, 1, 1, 10, 0), 1, 0, 0);
    run(mk_rec(3'b100, 1, 0, 40, 25), 1, 0, 0);
    run(mk_rec(3'b010, 0, 1, 7, 99), 0, 0, 0);
    run(mk_rec(3'b010, 0, 1, 33, 12), 1, 5, 0);
    run(mk_rec(3'b001, 1, 0, 5, 3), 1, 0, 1);
    run(mk_rec(3'b011, 1, 1, 8, 0), 1, 0, 0);
    run(mk_rec(3'b100, 0, 0, 8, 4), 1, 0, 0);
    for (int i = 0; i < 30; i++) run(rand_rec(), $urandom_range(0, 4) != 0, $urandom_range(0, 3), 0);
    en = 0;
    repeat (6) @(negedge clk);
    check("idle_no_qry", trade_qry, 0);
    check("idle_not_busy", busy, 0);
    force dut.trade_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.trade_cnt_r;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    check("preload_cnt", trade_cnt_r, exp_cnt);
    en = 1;
    run(mk_rec(3'b001, 1, 1, 77, 0), 1, 0, 0);
    check("cnt_wrap", trade_cnt_r, 16'h0000);
    wait_qry(seen);
    @(negedge clk);
    trade_vld_r = 1;
    trade_r = mk_rec(3'b100, 1, 1, 55, 0);
    @(negedge clk);
    trade_vld_r = 0;
    en = 0;
    @(negedge clk);
    check("pre_reset_emit", rsp_vld, 1);
    rst_n = 0;
    #1;
    check("reset_emit_ctl", ctl, 0);
    check("reset_emit_rsp", rsp_r, 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= int'(trade_qry);
    end
    check("en_low_no_qry", seen, 0);
    check("post_reset_cnt", trade_cnt_r, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
